// File: rtl/lfsr_multi.sv
// lfsr_multi: XNOR Fibonacci LFSR that advances STEPS single shifts per enabled clock.
// Define LFSR_MULTI_PERIOD_CNT_EN to add the step counter and the o_Period output.
module lfsr_multi #(
  parameter int          NUM_BITS = 8,
  parameter int          STEPS    = 1,
  parameter logic [31:0] TAPS     = 32'd0
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic [STEPS-1:0]    o_LFSR_Bits,
  output logic                o_LFSR_Valid,
  output logic                o_LFSR_Done,
  output logic                o_Lockup
`ifdef LFSR_MULTI_PERIOD_CNT_EN
  ,
  output logic [NUM_BITS:0]   o_Period
`endif
);

  function automatic logic [31:0] tap_bit(input logic [5:0] k);
    return 32'd1 << (k - 6'd1);
  endfunction

  // Maximal-length XNOR taps (XAPP052), bit k-1 set for tap k.
  function automatic logic [31:0] table_taps(input logic [5:0] n);
    logic [31:0] m;
    case (n)
      6'd3:    m = tap_bit(6'd3)  | tap_bit(6'd2);
      6'd4:    m = tap_bit(6'd4)  | tap_bit(6'd3);
      6'd5:    m = tap_bit(6'd5)  | tap_bit(6'd3);
      6'd6:    m = tap_bit(6'd6)  | tap_bit(6'd5);
      6'd7:    m = tap_bit(6'd7)  | tap_bit(6'd6);
      6'd8:    m = tap_bit(6'd8)  | tap_bit(6'd6)  | tap_bit(6'd5) | tap_bit(6'd4);
      6'd9:    m = tap_bit(6'd9)  | tap_bit(6'd5);
      6'd10:   m = tap_bit(6'd10) | tap_bit(6'd7);
      6'd11:   m = tap_bit(6'd11) | tap_bit(6'd9);
      6'd12:   m = tap_bit(6'd12) | tap_bit(6'd6)  | tap_bit(6'd4) | tap_bit(6'd1);
      6'd13:   m = tap_bit(6'd13) | tap_bit(6'd4)  | tap_bit(6'd3) | tap_bit(6'd1);
      6'd14:   m = tap_bit(6'd14) | tap_bit(6'd5)  | tap_bit(6'd3) | tap_bit(6'd1);
      6'd15:   m = tap_bit(6'd15) | tap_bit(6'd14);
      6'd16:   m = tap_bit(6'd16) | tap_bit(6'd15) | tap_bit(6'd13) | tap_bit(6'd4);
      6'd17:   m = tap_bit(6'd17) | tap_bit(6'd14);
      6'd18:   m = tap_bit(6'd18) | tap_bit(6'd11);
      6'd19:   m = tap_bit(6'd19) | tap_bit(6'd6)  | tap_bit(6'd2) | tap_bit(6'd1);
      6'd20:   m = tap_bit(6'd20) | tap_bit(6'd17);
      6'd21:   m = tap_bit(6'd21) | tap_bit(6'd19);
      6'd22:   m = tap_bit(6'd22) | tap_bit(6'd21);
      6'd23:   m = tap_bit(6'd23) | tap_bit(6'd18);
      6'd24:   m = tap_bit(6'd24) | tap_bit(6'd23) | tap_bit(6'd22) | tap_bit(6'd17);
      6'd25:   m = tap_bit(6'd25) | tap_bit(6'd22);
      6'd26:   m = tap_bit(6'd26) | tap_bit(6'd6)  | tap_bit(6'd2) | tap_bit(6'd1);
      6'd27:   m = tap_bit(6'd27) | tap_bit(6'd5)  | tap_bit(6'd2) | tap_bit(6'd1);
      6'd28:   m = tap_bit(6'd28) | tap_bit(6'd25);
      6'd29:   m = tap_bit(6'd29) | tap_bit(6'd27);
      6'd30:   m = tap_bit(6'd30) | tap_bit(6'd6)  | tap_bit(6'd4) | tap_bit(6'd1);
      6'd31:   m = tap_bit(6'd31) | tap_bit(6'd28);
      6'd32:   m = tap_bit(6'd32) | tap_bit(6'd22) | tap_bit(6'd2) | tap_bit(6'd1);
      default: m = 32'd0;
    endcase
    return m;
  endfunction

  function automatic logic xnor_fb(input logic [NUM_BITS-1:0] s, input logic [NUM_BITS-1:0] mask);
    return ~^(s & mask);
  endfunction

  localparam logic [31:0]         TAP_SEL  = (TAPS == 32'd0) ? table_taps(6'(NUM_BITS)) : TAPS;
  localparam logic [NUM_BITS-1:0] TAP_MASK = TAP_SEL[NUM_BITS-1:0];
  localparam int                  CW       = NUM_BITS + 32'sd1;

  generate
    if (NUM_BITS < 32'sd3 || NUM_BITS > 32'sd32) begin : g_bad_num_bits
      $error("lfsr_multi: NUM_BITS=%0d outside 3..32", NUM_BITS);
    end
    if (STEPS < 32'sd1 || STEPS > NUM_BITS) begin : g_bad_steps
      $error("lfsr_multi: STEPS=%0d outside 1..NUM_BITS", STEPS);
    end
    if (TAPS != 32'd0 && TAPS[NUM_BITS-1] == 1'b0) begin : g_bad_taps
      $error("lfsr_multi: TAPS must include tap NUM_BITS");
    end
  endgenerate

  logic [NUM_BITS-1:0] state_r;
  logic [NUM_BITS-1:0] seed_r;
  logic [STEPS-1:0]    bits_r;
  logic                valid_r;
  logic                done_r;
  logic [NUM_BITS-1:0] walk_s;
  logic [STEPS-1:0]    bits_s;
  logic                hit_s;
  logic                lockup_s;
`ifdef LFSR_MULTI_PERIOD_CNT_EN
  logic [CW-1:0]       hit_steps_s;
  logic [CW-1:0]       cnt_r;
  logic [CW-1:0]       period_r;
`endif

  // Unroll STEPS shifts; flag the first intermediate state that equals the stored seed.
  always_comb begin
    walk_s = state_r;
    bits_s = {STEPS{1'b0}};
    hit_s  = 1'b0;
`ifdef LFSR_MULTI_PERIOD_CNT_EN
    hit_steps_s = {CW{1'b0}};
`endif
    for (int i = 32'sd0; i < STEPS; i++) begin
      bits_s[STEPS-1-i] = xnor_fb(walk_s, TAP_MASK);
      walk_s = {walk_s[NUM_BITS-2:0], bits_s[STEPS-1-i]};
`ifdef LFSR_MULTI_PERIOD_CNT_EN
      if (!hit_s && walk_s == seed_r) begin
        hit_steps_s = CW'(i + 32'sd1);
      end else begin
        hit_steps_s = hit_steps_s;
      end
`endif
      hit_s = hit_s | (walk_s == seed_r);
    end
  end

  assign lockup_s = (state_r == {NUM_BITS{1'b1}});

  // State, stored seed and registered status; reset beats seed load beats advance.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_r <= {NUM_BITS{1'b0}};
      seed_r  <= {NUM_BITS{1'b0}};
      bits_r  <= {STEPS{1'b0}};
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else if (i_Seed_DV) begin
      state_r <= i_Seed_Data;
      seed_r  <= i_Seed_Data;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else if (i_Enable && !lockup_s) begin
      state_r <= walk_s;
      bits_r  <= bits_s;
      valid_r <= 1'b1;
      done_r  <= hit_s;
    end else begin
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end
  end

`ifdef LFSR_MULTI_PERIOD_CNT_EN
  // Single-step counter; on a seed return the distance is latched and the leftover steps carried.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_r    <= {CW{1'b0}};
      period_r <= {CW{1'b0}};
    end else if (i_Seed_DV) begin
      cnt_r    <= {CW{1'b0}};
    end else if (i_Enable && !lockup_s) begin
      if (hit_s) begin
        period_r <= cnt_r + hit_steps_s;
        cnt_r    <= CW'(STEPS) - hit_steps_s;
      end else begin
        cnt_r    <= cnt_r + CW'(STEPS);
      end
    end else begin
      cnt_r    <= cnt_r;
    end
  end

  assign o_Period = period_r;
`endif

  assign o_LFSR_Data  = state_r;
  assign o_LFSR_Bits  = bits_r;
  assign o_LFSR_Valid = valid_r;
  assign o_LFSR_Done  = done_r;
  assign o_Lockup     = lockup_s;

endmodule

// File: tb/tb_lfsr_multi.sv
// tb_lfsr_multi: six lfsr_multi configurations driven side by side against a step-by-step
// reference model built from tap-position lists.
module tb_lfsr_multi;

  localparam int          NS[6]  = '{4, 4, 8, 5, 5, 32};
  localparam int          SS[6]  = '{1, 2, 1, 1, 1, 8};
  localparam int          GID[6] = '{0, 0, 1, 2, 2, 3};
  localparam logic [31:0] TS[6]  = '{32'd0, 32'd0, 32'd0, 32'b10100, 32'd0, 32'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_g[4], en_g[4], sd_g[4];
  logic [31:0] seed_g[4];

  logic [63:0] o_data[6], o_bits[6];
  logic        o_valid[6], o_done[6], o_lock[6];
`ifdef LFSR_MULTI_PERIOD_CNT_EN
  logic [63:0] o_per[6];
`endif

  longint m_st[6], m_seed[6], m_bits[6], m_cnt[6], m_per[6];
  bit     m_valid[6], m_done[6], m_lock[6];
  int     nvec = 0;
  int     nerr = 0;

  for (genvar g = 0; g < 6; g++) begin : g_dut
    localparam int N = NS[g];
    localparam int S = SS[g];
    logic [N-1:0] d;
    logic [S-1:0] b;
    logic         v, dn, lk;
`ifdef LFSR_MULTI_PERIOD_CNT_EN
    logic [N:0]   p;
`endif
    lfsr_multi #(.NUM_BITS(N), .STEPS(S), .TAPS(TS[g])) u_dut (
      .i_Clk(clk), .i_Rst(rst_g[GID[g]]), .i_Enable(en_g[GID[g]]), .i_Seed_DV(sd_g[GID[g]]),
      .i_Seed_Data(seed_g[GID[g]][N-1:0]), .o_LFSR_Data(d), .o_LFSR_Bits(b),
      .o_LFSR_Valid(v), .o_LFSR_Done(dn), .o_Lockup(lk)
`ifdef LFSR_MULTI_PERIOD_CNT_EN
      , .o_Period(p)
`endif
    );
    assign o_data[g]  = {{(64-N){1'b0}}, d};
    assign o_bits[g]  = {{(64-S){1'b0}}, b};
    assign o_valid[g] = v;
    assign o_done[g]  = dn;
    assign o_lock[g]  = lk;
`ifdef LFSR_MULTI_PERIOD_CNT_EN
    assign o_per[g]   = {{(63-N){1'b0}}, p};
`endif
  end

  // One XNOR shift from the published tap positions: feedback is 1 when an even number of taps are set.
  function automatic longint step1(input longint st, input int n, output bit fb);
    int t[$];
    int ones;
    case (n)
      4:       t = '{4, 3};
      5:       t = '{5, 3};
      8:       t = '{8, 6, 5, 4};
      32:      t = '{32, 22, 2, 1};
      default: t = '{};
    endcase
    ones = 0;
    foreach (t[i]) ones += int'((st >> (t[i] - 1)) & 64'd1);
    fb = (ones % 2) == 0;
    return ((st << 1) | longint'(fb)) & ((longint'(1) << n) - 1);
  endfunction

  task automatic model_cycle(input int id);
    int     gid;
    longint full, b;
    bit     d, fb;
    gid  = GID[id];
    full = (longint'(1) << NS[id]) - 1;
    if (rst_g[gid] === 1'b1) begin
      m_st[id] = 0; m_seed[id] = 0; m_bits[id] = 0; m_cnt[id] = 0; m_per[id] = 0;
      m_valid[id] = 0; m_done[id] = 0;
    end else if (sd_g[gid] === 1'b1) begin
      m_st[id] = longint'(seed_g[gid]) & full;
      m_seed[id] = m_st[id]; m_cnt[id] = 0; m_valid[id] = 0; m_done[id] = 0;
    end else if (en_g[gid] === 1'b1 && m_st[id] != full) begin
      b = 0; d = 0;
      for (int k = 0; k < SS[id]; k++) begin
        m_st[id] = step1(m_st[id], NS[id], fb);
        b = (b << 1) | longint'(fb);
        m_cnt[id]++;
        if (!d && m_st[id] == m_seed[id]) begin
          d = 1; m_per[id] = m_cnt[id]; m_cnt[id] = 0;
        end
      end
      m_bits[id] = b; m_valid[id] = 1; m_done[id] = d;
    end else begin
      m_valid[id] = 0; m_done[id] = 0;
    end
    m_lock[id] = (m_st[id] == full);
  endtask

  task automatic drive(input int gid, input bit rst, input bit sd, input bit en, input logic [31:0] seed);
    rst_g[gid] = rst; sd_g[gid] = sd; en_g[gid] = en; seed_g[gid] = seed;
  endtask

  task automatic cycle();
    for (int id = 0; id < 6; id++) model_cycle(id);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int g = 0; g < 4; g++) drive(g, 1'b1, 1'b1, 1'b1, $urandom);
    cycle();
    cycle();
    for (int id = 0; id < 6; id++) begin
      nvec++;
      if (o_data[id] !== 64'd0 || o_bits[id] !== 64'd0 || o_valid[id] !== 1'b0 ||
          o_done[id] !== 1'b0 || o_lock[id] !== 1'b0) begin
        nerr++;
        $display("FAIL reset id%0d: data=%h bits=%h v=%b d=%b lk=%b, required all 0",
                 id, o_data[id], o_bits[id], o_valid[id], o_done[id], o_lock[id]);
      end
    end
    for (int g = 0; g < 4; g++) drive(g, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle();
  endtask

  task automatic test_seq4();
    logic [3:0]  first5[5];
    logic [15:0] seen;
    int          nd0, nd1;
    first5 = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD};
    seen = 16'd0; nd0 = 0; nd1 = 0;
    drive(0, 1'b0, 1'b0, 1'b1, 32'd0);
    for (int c = 1; c <= 30; c++) begin
      cycle();
      for (int id = 0; id < 2; id++) begin
        nvec++;
        if (o_data[id] !== m_st[id] || o_bits[id] !== m_bits[id] || o_valid[id] !== m_valid[id] ||
            o_done[id] !== m_done[id] || o_lock[id] !== m_lock[id]) begin
          nerr++;
          $display("FAIL seq4 id%0d cyc%0d: data=%h bits=%h v=%b d=%b, expected data=%h bits=%h v=%b d=%b",
                   id, c, o_data[id], o_bits[id], o_valid[id], o_done[id],
                   m_st[id], m_bits[id], m_valid[id], m_done[id]);
        end
      end
      nd0 += int'(o_done[0] === 1'b1);
      nd1 += int'(o_done[1] === 1'b1);
      if (c <= 15) seen[o_data[0][3:0]] = 1'b1;
      if (c <= 5) begin
        nvec++;
        if (o_data[0][3:0] !== first5[c-1]) begin
          nerr++;
          $display("FAIL seq4_start cyc%0d: data=%h, required %h", c, o_data[0][3:0], first5[c-1]);
        end
      end
      if (c == 1 || c == 2) begin
        nvec++;
        if ({o_data[1][3:0], o_bits[1][1:0]} !== (c == 1 ? 6'b0011_11 : 6'b1110_10)) begin
          nerr++;
          $display("FAIL steps2 cyc%0d: data=%h bits=%b", c, o_data[1][3:0], o_bits[1][1:0]);
        end
      end
      if (c == 8 || c == 15) begin
        nvec++;
        if (o_done[1] !== 1'b1 || o_done[0] !== (c == 15)) begin
          nerr++;
          $display("FAIL done_pos cyc%0d: done1=%b done0=%b", c, o_done[1], o_done[0]);
        end
`ifdef LFSR_MULTI_PERIOD_CNT_EN
        nvec++;
        if (o_per[1] !== 64'd15 || (c == 15 && o_per[0] !== 64'd15)) begin
          nerr++;
          $display("FAIL period4 cyc%0d: per1=%0d per0=%0d, required 15", c, o_per[1], o_per[0]);
        end
`endif
      end
    end
    nvec++;
    if (nd0 != 2 || nd1 != 4) begin
      nerr++;
      $display("FAIL done_count: steps1=%0d steps2=%0d, required 2 and 4", nd0, nd1);
    end
    nvec++;
    if (seen[15] !== 1'b0 || $countones(seen) != 15) begin
      nerr++;
      $display("FAIL distinct4: seen=%b, required 15 values without 0xF", seen);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_seed_lockup();
    drive(0, 1'b0, 1'b1, 1'b1, 32'hF);
    for (int c = 0; c <= 10; c++) begin
      cycle();
      drive(0, 1'b0, 1'b0, 1'b1, 32'd0);
      for (int id = 0; id < 2; id++) begin
        nvec++;
        if (o_data[id] !== 64'hF || o_lock[id] !== 1'b1 || o_valid[id] !== 1'b0) begin
          nerr++;
          $display("FAIL lockup_hold id%0d cyc%0d: data=%h lk=%b v=%b, required data=f lk=1 v=0",
                   id, c, o_data[id], o_lock[id], o_valid[id]);
        end
      end
    end
    drive(0, 1'b0, 1'b1, 1'b0, 32'd0);
    cycle();
    drive(0, 1'b0, 1'b0, 1'b1, 32'd0);
    cycle();
    nvec++;
    if (o_lock[0] !== 1'b0 || o_data[0] !== 64'h1 || o_data[1] !== 64'h3 || o_valid[0] !== 1'b1) begin
      nerr++;
      $display("FAIL lockup_clear: lk=%b data0=%h data1=%h v=%b, required 0 1 3 1",
               o_lock[0], o_data[0], o_data[1], o_valid[0]);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_priority();
    logic [31:0] s;
    s = 32'($urandom_range(0, 14));
    drive(0, 1'b0, 1'b1, 1'b1, s);
    cycle();
    nvec++;
    if (o_data[0] !== 64'(s) || o_data[1] !== 64'(s) || o_valid[0] !== 1'b0 || o_done[0] !== 1'b0) begin
      nerr++;
      $display("FAIL seed_over_enable: data=%h/%h v=%b d=%b, required data=%h v=0 d=0",
               o_data[0], o_data[1], o_valid[0], o_done[0], s);
    end
    drive(0, 1'b0, 1'b0, 1'b1, 32'd0);
    repeat (3) cycle();
    drive(0, 1'b1, 1'b1, 1'b1, $urandom);
    cycle();
    for (int id = 0; id < 2; id++) begin
      nvec++;
      if (o_data[id] !== 64'd0 || o_bits[id] !== 64'd0 || o_valid[id] !== 1'b0 ||
          o_done[id] !== 1'b0 || o_lock[id] !== 1'b0) begin
        nerr++;
        $display("FAIL reset_over_seed id%0d: data=%h bits=%h v=%b d=%b lk=%b, required all 0",
                 id, o_data[id], o_bits[id], o_valid[id], o_done[id], o_lock[id]);
      end
    end
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle();
  endtask

  task automatic test_seed_a5();
    int nd;
    nd = 0;
    drive(1, 1'b0, 1'b1, 1'b0, 32'hA5);
    cycle();
    nvec++;
    if (o_data[2] !== 64'hA5 || o_valid[2] !== 1'b0) begin
      nerr++;
      $display("FAIL seed_a5: data=%h v=%b, required a5 0", o_data[2], o_valid[2]);
    end
    drive(1, 1'b0, 1'b0, 1'b1, 32'd0);
    for (int c = 1; c <= 255; c++) begin
      cycle();
      nd += int'(o_done[2] === 1'b1);
      nvec++;
      if (o_data[2] !== m_st[2] || o_bits[2] !== m_bits[2] || o_valid[2] !== 1'b1 || o_done[2] !== m_done[2]) begin
        nerr++;
        $display("FAIL run8 cyc%0d: data=%h bits=%h v=%b d=%b, expected data=%h bits=%h v=1 d=%b",
                 c, o_data[2], o_bits[2], o_valid[2], o_done[2], m_st[2], m_bits[2], m_done[2]);
      end
    end
    nvec++;
    if (o_done[2] !== 1'b1 || o_data[2] !== 64'hA5 || nd != 1) begin
      nerr++;
      $display("FAIL period8: done=%b data=%h count=%0d, required 1 a5 1", o_done[2], o_data[2], nd);
    end
`ifdef LFSR_MULTI_PERIOD_CNT_EN
    nvec++;
    if (o_per[2] !== 64'd255) begin
      nerr++;
      $display("FAIL o_period8: got %0d, required 255", o_per[2]);
    end
`endif
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_taps5();
    drive(2, 1'b0, 1'b0, 1'b1, 32'd0);
    for (int c = 1; c <= 31; c++) begin
      cycle();
      nvec++;
      if (o_data[3] !== o_data[4] || o_data[3] !== m_st[3] || o_done[3] !== m_done[3] || o_done[4] !== m_done[4]) begin
        nerr++;
        $display("FAIL taps5 cyc%0d: override=%h table=%h done=%b/%b, expected %h done=%b",
                 c, o_data[3], o_data[4], o_done[3], o_done[4], m_st[3], m_done[3]);
      end
    end
    nvec++;
    if (o_done[3] !== 1'b1 || o_done[4] !== 1'b1 || o_data[3] !== 64'd0) begin
      nerr++;
      $display("FAIL taps5_period: done=%b/%b data=%h, required 1 1 0", o_done[3], o_done[4], o_data[3]);
    end
    drive(2, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_wide32();
    logic [31:0] s;
    s = $urandom;
    if (s == 32'hFFFF_FFFF) s = 32'h1;
    drive(3, 1'b0, 1'b1, 1'b0, s);
    cycle();
    drive(3, 1'b0, 1'b0, 1'b1, 32'd0);
    for (int c = 1; c <= 1000; c++) begin
      cycle();
      nvec++;
      if (o_data[5] !== m_st[5] || o_bits[5] !== m_bits[5] || o_done[5] !== 1'b0 || o_lock[5] !== 1'b0) begin
        nerr++;
        $display("FAIL wide32 cyc%0d: data=%h bits=%h d=%b lk=%b, expected data=%h bits=%h d=0 lk=0",
                 c, o_data[5], o_bits[5], o_done[5], o_lock[5], m_st[5], m_bits[5]);
      end
    end
    drive(3, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_random();
    for (int c = 1; c <= 400; c++) begin
      for (int g = 0; g < 4; g++) begin
        drive(g, $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
              (g == 0 && $urandom_range(0, 3) == 0) ? 32'hF : $urandom);
      end
      cycle();
      for (int id = 0; id < 6; id++) begin
        nvec++;
        if (o_data[id] !== m_st[id] || o_bits[id] !== m_bits[id] || o_valid[id] !== m_valid[id] ||
            o_done[id] !== m_done[id] || o_lock[id] !== m_lock[id]) begin
          nerr++;
          $display("FAIL random id%0d cyc%0d: data=%h bits=%h v=%b d=%b lk=%b, expected data=%h bits=%h v=%b d=%b lk=%b",
                   id, c, o_data[id], o_bits[id], o_valid[id], o_done[id], o_lock[id],
                   m_st[id], m_bits[id], m_valid[id], m_done[id], m_lock[id]);
        end
`ifdef LFSR_MULTI_PERIOD_CNT_EN
        nvec++;
        if (o_per[id] !== m_per[id]) begin
          nerr++;
          $display("FAIL random_period id%0d cyc%0d: got %0d, expected %0d", id, c, o_per[id], m_per[id]);
        end
`endif
      end
    end
  endtask

  initial begin
    for (int g = 0; g < 4; g++) drive(g, 1'b1, 1'b0, 1'b0, 32'd0);
    test_reset();
    test_seq4();
    test_seed_lockup();
    test_priority();
    test_seed_a5();
    test_taps5();
    test_wide32();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lfsr_multi.md
Name: lfsr_multi

Overview:
- Parametrised successor to the team's single-step XNOR LFSR, for pseudo-random stimulus, scrambler seeds and test-pattern generation.
- Advances STEPS shifts per enabled clock.
- Supports a tap-mask override and synchronous reset.
- Reports the bits shifted out, sequence completion against the loaded seed, and the XNOR lock-up state.

Parameters:
- NUM_BITS, 8, register width; legal 3..32.
- STEPS, 1, single-bit shifts per enabled clock; legal 1..NUM_BITS.
- TAPS, 0, tap mask, bit k-1 = tap k. 0 selects the built-in maximal-length table (XAPP052 taps for 3..32, e.g. 4:{4,3}, 8:{8,6,5,4}, 16:{16,15,13,4}).

Ports:
- i_Clk, input, 1, sole clock; all logic on rising edge.
- i_Rst, input, 1, synchronous active-high reset.
- i_Enable, input, 1, advance the LFSR by STEPS this cycle.
- i_Seed_DV, input, 1, load i_Seed_Data this cycle.
- i_Seed_Data, input, NUM_BITS, seed value.
- o_LFSR_Data, output, NUM_BITS, current state (bit NUM_BITS-1 = tap NUM_BITS).
- o_LFSR_Bits, output, STEPS, feedback bits generated in the last advance, oldest in bit STEPS-1.
- o_LFSR_Valid, output, 1, registered; high the cycle after an advance.
- o_LFSR_Done, output, 1, registered one-cycle pulse when the sequence returns to the seed.
- o_Lockup, output, 1, state is all-ones (XNOR lock-up).

Behaviour:
- Reset (i_Rst=1, synchronous, overrides everything):
  - state = 0, stored seed = 0.
  - o_LFSR_Bits = 0, o_LFSR_Valid = 0, o_LFSR_Done = 0, o_Lockup = 0.
- Feedback (Fibonacci, XNOR):
  - fb = XNOR-reduction of the tapped bits.
  - Next state = {state[NUM_BITS-2:0], fb}.
  - One enabled cycle applies STEPS such shifts combinationally, unrolled.
  - o_LFSR_Bits captures the STEPS fb values of that cycle.
- Priority per cycle: i_Rst > i_Seed_DV > i_Enable.
- Seed load:
  - Happens whenever i_Seed_DV=1, independent of i_Enable.
  - state and stored seed both take i_Seed_Data.
  - No advance that cycle; o_LFSR_Valid = 0 and o_LFSR_Done = 0 next cycle.
- Advance: when i_Enable=1 and i_Seed_DV=0 and o_Lockup=0, the state moves by STEPS and o_LFSR_Valid = 1 next cycle.
- Done:
  - Each of the STEPS intermediate states is compared with the stored seed.
  - Any match pulses o_LFSR_Done for one cycle, aligned with o_LFSR_Valid.
  - Period is 2^NUM_BITS-1 single steps.
  - If STEPS does not divide the period, Done still fires once per return to the seed.
- Lock-up:
  - o_Lockup is combinational: state == all-ones.
  - While set, i_Enable is ignored and the state holds.
  - Cleared only by reset or a seed load of any other value.
  - Loading all-ones as seed asserts o_Lockup immediately.
- i_Enable low: state, o_LFSR_Bits and the stored seed hold; o_LFSR_Valid and o_LFSR_Done are 0.
- Parameter errors: illegal NUM_BITS/STEPS, or TAPS with bit NUM_BITS-1 clear, abort elaboration via a generate-time error.

Optional Feature:
- Macro: LFSR_MULTI_PERIOD_CNT_EN.
- When defined:
  - Adds output o_Period[NUM_BITS:0] and an internal counter of single steps.
  - Counter clears on reset and on seed load, and adds STEPS per advance.
  - On Done it latches the step count up to the matching intermediate state into o_Period, then restarts the count from the remaining steps.
  - o_Period holds until the next Done; reset value 0.
- When undefined: no counter and no o_Period port; behaviour otherwise identical.

Test Plan:
- NUM_BITS=4, STEPS=1: reset, then i_Enable=1 → o_LFSR_Data 0x1, 0x3, 0x7, 0xE, 0xD…; o_LFSR_Done pulses exactly every 15 enabled cycles; 15 distinct values, never 0xF.
- NUM_BITS=4, STEPS=2, from reset: first advance → 0x3 with o_LFSR_Bits=2'b11; second → 0xE with o_LFSR_Bits=2'b10; Done fires on the 8th advance (step 15 falls mid-cycle).
- Seed 0xA5 (NUM_BITS=8) with i_Enable=0 → o_LFSR_Data=0xA5 next cycle, o_LFSR_Valid=0. Then enable for 255 cycles → Done pulses on cycle 255 with state 0xA5; with LFSR_MULTI_PERIOD_CNT_EN, o_Period=255.
- Seed 0xF (NUM_BITS=4) → o_Lockup=1 and state held at 0xF under i_Enable=1 for 10 cycles; then seed 0x0 → o_Lockup=0 and advancing resumes (0x1).
- Simultaneous i_Seed_DV=1, i_Enable=1 → seed loaded, no advance. i_Rst=1 mid-sequence with i_Seed_DV=1 → state 0, all outputs 0 next cycle.
- NUM_BITS=5, TAPS=5'b10100 ({5,3}) vs TAPS=0 → identical sequences over 31 cycles; NUM_BITS=32, STEPS=8 → 1000 cycles with no repeat of the seed and no lock-up.
